// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame state encoding, frame geometry and the
// scancode prefixes the downstream keyboard command controller also decodes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int         FRAME_DATA_BITS = 8;
    localparam logic [7:0] SC_BREAK        = 8'hF0;
    localparam logic [7:0] SC_EXTENDED     = 8'hE0;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Pin and scancode bundle between the PS/2 receiver and its neighbours: the
// device side drives the pins, the receiver side returns decoded bytes.
interface ps2_scancode_rx_if;

    logic       ps2_clock;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       valid;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output ps2_clock, ps2_data,
        input  scancode, valid, parity_err, frame_err
    );

    modport slave (
        input  ps2_clock, ps2_data,
        output scancode, valid, parity_err, frame_err
    );

endinterface

// File: rtl/ps2_clock_filter.sv
// Synchronises both PS/2 pins, de-glitches the clock and emits a one-cycle
// pulse on each settled falling edge of the filtered clock.
module ps2_clock_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic ps2_clock_i,
    input  logic ps2_data_i,
    output logic sync_data_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   filt_prev_q;
    logic                   sync_clk;

    assign sync_clk    = clk_sync_q[SYNC_STAGES-1];
    assign sync_data_o = data_sync_q[SYNC_STAGES-1];
    assign fall_o      = filt_prev_q & ~filt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            cnt_q       <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clock_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_clk != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver: deserialises start/8 data/parity/stop on
// filtered falling edges and reports good bytes, parity errors and framing errors.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk_in,
    input  logic             reset_n,
    ps2_scancode_rx_if.slave bus
);

    localparam int BCW = $clog2(FRAME_DATA_BITS);
    localparam int WW  = $clog2(TIMEOUT_CYCLES);

    rx_state_t                  state_q, state_d;
    logic [BCW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic                       parity_q, parity_d;
    logic [WW-1:0]              wd_q, wd_d;
    logic [7:0]                 scancode_q, scancode_d;
    logic                       valid_q, valid_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;
    logic                       sync_data;
    logic                       fall;
    logic                       timeout;

    ps2_clock_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .ps2_clock_i (bus.ps2_clock),
        .ps2_data_i  (bus.ps2_data),
        .sync_data_o (sync_data),
        .fall_o      (fall)
    );

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            wd_q       <= '0;
            scancode_q <= 8'h00;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            wd_q       <= wd_d;
            scancode_q <= scancode_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // A stalled frame must not be completed by a late edge, so timeout outranks fall.
    assign timeout = (state_q != IDLE) && (wd_q == WW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        scancode_d = scancode_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        wd_d       = (state_q == IDLE || fall) ? '0 : wd_q + WW'(1);

        if (timeout) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            ferr_d    = 1'b1;
            wd_d      = '0;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!sync_data) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d[bit_cnt_q] = sync_data;
                    bit_cnt_d          = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(FRAME_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = sync_data;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!sync_data) begin
                        ferr_d = 1'b1;
                    end else if (!odd_parity_ok(shift_q, parity_q)) begin
                        perr_d = 1'b1;
                    end else begin
                        valid_d    = 1'b1;
                        scancode_d = shift_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.scancode   = scancode_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: clean, back-to-back, corrupted, glitched,
// truncated and reset-interrupted PS/2 frames with hand-computed results.
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 1000;
    // Half a PS/2 bit; the full bit period must stay below the watchdog limit.
    localparam int HALF_BIT       = 100;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errs    = 0;

    int         n_valid = 0;
    int         n_perr  = 0;
    int         n_ferr  = 0;
    logic [7:0] sc_log[$];
    int         last_fall_cyc = 0;

    ps2_scancode_rx_if pins ();

    ps2_scancode_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (pins)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (pins.valid) begin
            n_valid = n_valid + 1;
            sc_log.push_back(pins.scancode);
        end
        if (pins.parity_err) n_perr = n_perr + 1;
        if (pins.frame_err)  n_ferr = n_ferr + 1;
    end

    task automatic send_bit(input logic b);
        @(negedge clk_in);
        pins.ps2_data = b;
        repeat (HALF_BIT) @(negedge clk_in);
        pins.ps2_clock = 1'b0;
        last_fall_cyc  = cyc;
        repeat (HALF_BIT) @(negedge clk_in);
        pins.ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(bad_par ? ^b : ~^b);
        send_bit(stop_v);
        repeat (20) @(negedge clk_in);
    endtask

    task automatic check_counts(input string name, input int dv, input int dp, input int df,
                                input int v0, input int p0, input int f0);
        checks++;
        if ((n_valid - v0) !== dv || (n_perr - p0) !== dp || (n_ferr - f0) !== df) begin
            errs++;
            $display("FAIL %s: valid/parity_err/frame_err pulses %0d/%0d/%0d, expected %0d/%0d/%0d",
                     name, n_valid - v0, n_perr - p0, n_ferr - f0, dv, dp, df);
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        pins.ps2_clock = 1'b1;
        pins.ps2_data  = 1'b1;
        repeat (5) @(negedge clk_in);
        checks++;
        if ({pins.scancode, pins.valid, pins.parity_err, pins.frame_err} !== 11'h000) begin
            errs++;
            $display("FAIL reset_outputs: got sc=%h v=%b p=%b f=%b, expected all 0",
                     pins.scancode, pins.valid, pins.parity_err, pins.frame_err);
        end
        reset_n = 1'b1;
        repeat (50) @(negedge clk_in);
        check_counts("reset_idle_quiet", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_single();
        int v0 = n_valid, p0 = n_perr, f0 = n_ferr;
        send_frame(8'h1C, 1'b0, 1'b1);
        check_counts("single_1c_pulses", 1, 0, 0, v0, p0, f0);
        checks++;
        if (pins.scancode !== 8'h1C) begin
            errs++;
            $display("FAIL single_1c_scancode: got %h, expected 1c", pins.scancode);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = n_valid, p0 = n_perr, f0 = n_ferr;
        send_frame(SC_BREAK, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_counts("b2b_pulses", 2, 0, 0, v0, p0, f0);
        checks++;
        if (sc_log.size() < v0 + 2 || sc_log[v0] !== 8'hF0 || sc_log[v0 + 1] !== 8'h1C) begin
            errs++;
            $display("FAIL b2b_order: got %0d entries, expected f0 then 1c", sc_log.size() - v0);
        end
    endtask

    task automatic test_errors();
        int v0 = n_valid, p0 = n_perr, f0 = n_ferr;
        send_frame(8'h5A, 1'b1, 1'b1);
        check_counts("parity_err_pulses", 0, 1, 0, v0, p0, f0);
        checks++;
        if (pins.scancode !== 8'h1C) begin
            errs++;
            $display("FAIL parity_err_hold: got %h, expected 1c", pins.scancode);
        end
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h5A, 1'b0, 1'b0);
        check_counts("stop_err_pulses", 0, 0, 1, v0, p0, f0);
        checks++;
        if (pins.scancode !== 8'h1C) begin
            errs++;
            $display("FAIL stop_err_hold: got %h, expected 1c", pins.scancode);
        end
    endtask

    task automatic test_glitch();
        int         v0 = n_valid, p0 = n_perr, f0 = n_ferr;
        logic [7:0] b  = 8'h33;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(30, 90)) @(negedge clk_in);
            pins.ps2_data  = 1'b0;
            pins.ps2_clock = 1'b0;
            repeat (3) @(negedge clk_in);
            pins.ps2_clock = 1'b1;
        end
        repeat (10) @(negedge clk_in);
        pins.ps2_data = 1'b1;
        repeat (TIMEOUT_CYCLES + 100) @(negedge clk_in);
        check_counts("glitch_ignored", 0, 0, 0, v0, p0, f0);

        // An exactly FILTER_LEN-wide low is a genuine start-bit edge.
        pins.ps2_data  = 1'b0;
        repeat (HALF_BIT) @(negedge clk_in);
        pins.ps2_clock = 1'b0;
        repeat (FILTER_LEN) @(negedge clk_in);
        pins.ps2_clock = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b);
        send_bit(1'b1);
        repeat (20) @(negedge clk_in);
        check_counts("min_width_edge_pulses", 1, 0, 0, v0, p0, f0);
        checks++;
        if (pins.scancode !== 8'h33) begin
            errs++;
            $display("FAIL min_width_edge_scancode: got %h, expected 33", pins.scancode);
        end
    endtask

    task automatic test_timeout();
        int v0 = n_valid, p0 = n_perr, f0 = n_ferr;
        int t_err = -1;
        int t0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        t0 = last_fall_cyc;
        for (int i = 0; i < TIMEOUT_CYCLES + 200; i++) begin
            @(negedge clk_in);
            if (n_ferr != f0) begin
                t_err = cyc - t0;
                break;
            end
        end
        checks++;
        if (t_err < TIMEOUT_CYCLES || t_err > TIMEOUT_CYCLES + 40) begin
            errs++;
            $display("FAIL timeout_latency: got %0d cycles after last fall, expected %0d..%0d",
                     t_err, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 40);
        end
        repeat (20) @(negedge clk_in);
        check_counts("timeout_pulses", 0, 0, 1, v0, p0, f0);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h29, 1'b0, 1'b1);
        check_counts("after_timeout_pulses", 1, 0, 0, v0, p0, f0);
        checks++;
        if (pins.scancode !== 8'h29) begin
            errs++;
            $display("FAIL after_timeout_scancode: got %h, expected 29", pins.scancode);
        end
    endtask

    task automatic test_async_reset();
        int v0, p0, f0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        @(negedge clk_in);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pins.scancode, pins.valid, pins.parity_err, pins.frame_err} !== 11'h000) begin
            errs++;
            $display("FAIL async_reset_outputs: got sc=%h v=%b p=%b f=%b, expected all 0",
                     pins.scancode, pins.valid, pins.parity_err, pins.frame_err);
        end
        repeat (10) @(negedge clk_in);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_in);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h45, 1'b0, 1'b1);
        check_counts("after_reset_pulses", 1, 0, 0, v0, p0, f0);
        checks++;
        if (pins.scancode !== 8'h45) begin
            errs++;
            $display("FAIL after_reset_scancode: got %h, expected 45", pins.scancode);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_errors();
        test_glitch();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
